// File: rtl/reg_scoreboard_pkg.sv
// Shared constants and grant encoding for the register scoreboard and its writeback arbiter.
package reg_scoreboard_pkg;

    localparam int unsigned REG_ID_W         = 5;
    localparam logic [REG_ID_W-1:0] REG_X0   = '0;
    localparam int unsigned STARVE_LIMIT_DEF = 4;
    localparam int unsigned STARVE_W         = 4;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_WB0  = 2'd1,
        GNT_WB1  = 2'd2
    } gnt_e;

endpackage

// File: rtl/reg_scoreboard_wb_arbiter.sv
// Two-requester writeback arbiter: wb0 has priority, wb1 is forced through after
// STARVE_LIMIT consecutive refusals. Grant is combinational, counter is registered.
module reg_scoreboard_wb_arbiter
    import reg_scoreboard_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_wb0_valid,
    input  logic i_wb1_valid,
    output gnt_e o_gnt
);

    localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

    logic [STARVE_W-1:0] r_starve;
    logic [STARVE_W-1:0] w_starve_nxt;

    always_comb begin
        o_gnt = GNT_NONE;
        if (i_wb1_valid && (!i_wb0_valid || (r_starve == LIMIT))) begin
            o_gnt = GNT_WB1;
        end else if (i_wb0_valid) begin
            o_gnt = GNT_WB0;
        end
    end

    // Counter only runs while wb1 is actually waiting; any gap resets fairness.
    always_comb begin
        w_starve_nxt = r_starve;
        if (!i_wb1_valid || (o_gnt == GNT_WB1)) begin
            w_starve_nxt = '0;
        end else if (r_starve != LIMIT) begin
            w_starve_nxt = r_starve + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_starve <= '0;
        end else begin
            r_starve <= w_starve_nxt;
        end
    end

endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard: pending-write tracking, RAW/WAW issue stall and registered writeback commit.
// Optional macro SCOREBOARD_BYPASS_EN lets a committing register satisfy source operands early.
module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter int unsigned REG_NUM      = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_issue_valid,
    input  logic [REG_ID_W-1:0] i_issue_rs1,
    input  logic [REG_ID_W-1:0] i_issue_rs2,
    input  logic [REG_ID_W-1:0] i_issue_rd,
    input  logic                i_issue_rd_en,
    output logic                o_issue_ready,
    input  logic                i_wb0_valid,
    input  logic [REG_ID_W-1:0] i_wb0_rd,
    input  logic [DATA_W-1:0]   i_wb0_data,
    output logic                o_wb0_ready,
    input  logic                i_wb1_valid,
    input  logic [REG_ID_W-1:0] i_wb1_rd,
    input  logic [DATA_W-1:0]   i_wb1_data,
    output logic                o_wb1_ready,
    output logic                o_rf_w_en,
    output logic [REG_ID_W-1:0] o_rf_rd_id,
    output logic [DATA_W-1:0]   o_rf_wdata,
    output logic [REG_NUM-1:0]  o_busy_vec,
    output logic                o_err_spurious_wb,
    output logic                o_fwd_rs1_hit,
    output logic                o_fwd_rs2_hit,
    output logic [DATA_W-1:0]   o_fwd_data
);

    logic [REG_NUM-1:0]  r_busy;
    logic [REG_NUM-1:0]  w_busy_nxt;
    logic                r_rf_w_en;
    logic [REG_ID_W-1:0] r_rf_rd_id;
    logic [DATA_W-1:0]   r_rf_wdata;
    logic                r_err;

    gnt_e                w_gnt;
    logic                w_gnt_valid;
    logic [REG_ID_W-1:0] w_gnt_rd;
    logic [DATA_W-1:0]   w_gnt_data;
    logic                w_fwd_rs1;
    logic                w_fwd_rs2;
    logic                w_rs1_busy;
    logic                w_rs2_busy;
    logic                w_issue_fire;
    logic                w_spurious;

    reg_scoreboard_wb_arbiter #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_arb (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_wb0_valid (i_wb0_valid),
        .i_wb1_valid (i_wb1_valid),
        .o_gnt       (w_gnt)
    );

`ifdef SCOREBOARD_BYPASS_EN
    assign w_fwd_rs1  = r_rf_w_en && (r_rf_rd_id == i_issue_rs1);
    assign w_fwd_rs2  = r_rf_w_en && (r_rf_rd_id == i_issue_rs2);
    assign o_fwd_data = r_rf_wdata;
`else
    assign w_fwd_rs1  = 1'b0;
    assign w_fwd_rs2  = 1'b0;
    assign o_fwd_data = '0;
`endif

    assign o_fwd_rs1_hit = w_fwd_rs1;
    assign o_fwd_rs2_hit = w_fwd_rs2;

    // Forwarding relaxes only the source checks; WAW keeps using the raw busy bit.
    assign w_rs1_busy    = r_busy[i_issue_rs1] & ~w_fwd_rs1;
    assign w_rs2_busy    = r_busy[i_issue_rs2] & ~w_fwd_rs2;
    assign o_issue_ready = !(w_rs1_busy | w_rs2_busy | (i_issue_rd_en & r_busy[i_issue_rd]));
    assign w_issue_fire  = i_issue_valid & o_issue_ready;

    always_comb begin
        w_gnt_valid = 1'b0;
        w_gnt_rd    = i_wb0_rd;
        w_gnt_data  = i_wb0_data;
        case (w_gnt)
            GNT_WB0: begin
                w_gnt_valid = 1'b1;
            end
            GNT_WB1: begin
                w_gnt_valid = 1'b1;
                w_gnt_rd    = i_wb1_rd;
                w_gnt_data  = i_wb1_data;
            end
            default: w_gnt_valid = 1'b0;
        endcase
    end

    assign o_wb0_ready = (w_gnt == GNT_WB0);
    assign o_wb1_ready = (w_gnt == GNT_WB1);
    assign w_spurious  = w_gnt_valid && (w_gnt_rd != REG_X0) && !r_busy[w_gnt_rd];

    // Clear first, then set, so an issue and a commit on the same register leave it busy.
    always_comb begin
        w_busy_nxt = r_busy;
        if (r_rf_w_en) begin
            w_busy_nxt[r_rf_rd_id] = 1'b0;
        end
        if (w_issue_fire && i_issue_rd_en && (i_issue_rd != REG_X0)) begin
            w_busy_nxt[i_issue_rd] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_busy     <= '0;
            r_rf_w_en  <= 1'b0;
            r_rf_rd_id <= '0;
            r_rf_wdata <= '0;
            r_err      <= 1'b0;
        end else begin
            r_busy    <= w_busy_nxt;
            r_rf_w_en <= w_gnt_valid && (w_gnt_rd != REG_X0);
            if (w_gnt_valid) begin
                r_rf_rd_id <= w_gnt_rd;
                r_rf_wdata <= w_gnt_data;
            end
            if (w_spurious) begin
                r_err <= 1'b1;
            end
        end
    end

    assign o_rf_w_en         = r_rf_w_en;
    assign o_rf_rd_id        = r_rf_rd_id;
    assign o_rf_wdata        = r_rf_wdata;
    assign o_busy_vec        = r_busy;
    assign o_err_spurious_wb = r_err;

endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Sequences register-file access for the multi-cycle/pipelined core.
- Tracks a pending-write bit per architectural register and stalls issue on RAW or WAW hazards.
- Arbitrates two writeback requesters onto the single regfile write port (w_en / rd_id_i / rd_write_data_i):
  - wb0: short ALU path.
  - wb1: long-latency load/mul path.
- Sits between decode and regfile.

Parameters:
- REG_NUM, 32, number of architectural registers; x0 is hardwired.
- DATA_W, 32, writeback data width.
- STARVE_LIMIT, 4, consecutive cycles wb1 may be refused before it is forced to win; range 1..15.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- issue_valid  in  1  decode presents an instruction
- issue_rs1  in  5  source register 1
- issue_rs2  in  5  source register 2
- issue_rd  in  5  destination register
- issue_rd_en  in  1  instruction writes rd
- issue_ready  out  1  no hazard; issue accepted when issue_valid & issue_ready
- wb0_valid  in  1  ALU writeback request
- wb0_rd  in  5  destination register for wb0
- wb0_data  in  DATA_W  data for wb0
- wb0_ready  out  1  wb0 granted this cycle
- wb1_valid  in  1  long-latency writeback request
- wb1_rd  in  5  destination register for wb1
- wb1_data  in  DATA_W  data for wb1
- wb1_ready  out  1  wb1 granted this cycle
- rf_w_en  out  1  to regfile w_en (registered)
- rf_rd_id  out  5  to regfile rd_id_i (registered)
- rf_wdata  out  DATA_W  to regfile rd_write_data_i (registered)
- busy_vec  out  REG_NUM  pending-write bits (debug)
- err_spurious_wb  out  1  sticky: write granted to a non-busy register
- fwd_rs1_hit  out  1  bypass hit on rs1 (feature only)
- fwd_rs2_hit  out  1  bypass hit on rs2 (feature only)
- fwd_data  out  DATA_W  bypass data (feature only)

Behaviour:
- Reset (rst=1 at edge):
  - busy_vec=0, rf_w_en=0, rf_rd_id=0, rf_wdata=0.
  - starve counter=0, err_spurious_wb=0.
  - Combinational outputs follow from the cleared state.
- Hazard:
  - issue_ready = !(busy[rs1] | busy[rs2] | (issue_rd_en & busy[rd])).
  - busy[0] is constant 0.
  - issue_ready is combinational and independent of issue_valid.
- Issue: on accept with issue_rd_en and rd≠0, busy[rd] is set at the clock edge.
- Arbitration (combinational grant, one grant per cycle):
  - wb1 wins if wb1_valid & (!wb0_valid | starve==STARVE_LIMIT); otherwise wb0 wins if wb0_valid.
  - starve increments when wb1_valid & !wb1_ready, saturating at STARVE_LIMIT.
  - starve clears when wb1 is granted or wb1_valid=0.
  - Requesters hold valid/rd/data stable until their ready is seen.
- Commit:
  - The granted request is registered into rf_w_en/rf_rd_id/rf_wdata, giving 1-cycle latency.
  - rf_w_en=0 when the granted rd=0; the request is still consumed.
  - busy[rf_rd_id] clears at the edge where rf_w_en=1 is sampled, the same edge the regfile writes.
  - A dependent instruction is therefore ready 2 cycles after the grant cycle.
- Set/clear collision: an issue setting busy[r] and a commit clearing busy[r] at the same edge leaves the bit set (set wins). This is normally prevented by the WAW stall; the rule covers it anyway.
- Spurious write: a grant to rd≠0 with busy[rd]=0 sets err_spurious_wb until reset. The write is still performed.
- Reset mid-operation: all pending bits are dropped. An in-flight rf_w_en is cancelled at that edge.

Optional Feature:
- Macro: SCOREBOARD_BYPASS_EN.
- Defined:
  - A register being committed this cycle (rf_w_en & rf_rd_id==r) is treated as not busy for rs1/rs2 in the hazard check.
  - fwd_rs1_hit/fwd_rs2_hit flag the match; fwd_data=rf_wdata.
  - The dependent instruction is ready 1 cycle after the grant cycle.
  - WAW still uses the raw busy bit.
- Undefined: fwd_* tied to 0; behaviour as above.

Decomposition:
- Shared package/define file: REG_ID_W=5, REG_X0=0, STARVE_LIMIT default, arbiter grant encoding (GNT_NONE/GNT_WB0/GNT_WB1).
- Sub-module: wb_arbiter (two-requester priority arbiter with starvation counter, combinational grant, registered counter).
- reg_scoreboard keeps the busy bits, hazard logic and commit registers.

Test Plan:
- Reset then idle: busy_vec=0, rf_w_en=0, issue_ready=1 for rs1=3, rs2=4, rd=5.
- RAW stall:
  - Issue rd=5 at cycle 0.
  - Issue rs1=5 is stalled until wb0 (rd=5, data=0xA5) is granted in cycle k.
  - rf_w_en=1, rf_rd_id=5, rf_wdata=0xA5 at cycle k+1; issue_ready=1 at k+2 (k+1 with SCOREBOARD_BYPASS_EN, fwd_rs1_hit=1, fwd_data=0xA5).
- Arbitration and starvation:
  - wb0 and wb1 both valid continuously, STARVE_LIMIT=4.
  - wb0 is granted for 4 cycles, then wb1 is granted in the 5th; the counter then clears.
- x0 write: wb0 rd=0 data=0xFFFF_FFFF gives wb0_ready=1, rf_w_en stays 0, busy_vec unchanged, no error.
- Spurious and WAW:
  - wb1 rd=7 while busy[7]=0 sets err_spurious_wb=1 and holds it.
  - An issue with rd=9 busy gives issue_ready=0.
- Reset mid-flight: busy[3]=1 and grant pending, assert rst one cycle: busy_vec=0, rf_w_en=0 next cycle, err cleared.
